// File: rtl/alu_nibble_sequencer.sv
// rtl/alu_nibble_sequencer.sv - nibble-serial initiator for a 4-bit ALU slice
// Accepts one WIDTH-bit op, walks the slice one nibble per cycle and assembles result/flags.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4,
    parameter int WIDTH   = 4 * NIBBLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             illegal,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic             alu_cin,
    output logic             alu_less,
    output logic [2:0]       alu_op,
    input  logic [3:0]       alu_result,
    input  logic             alu_cout,
    input  logic             alu_set
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     nidx;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [2:0]        op_q;
    logic              legal_q;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  acc_next;
    logic [WIDTH-1:0]  fin_result;
    logic              last;
    logic              sub_q;
    logic              arith_q;
    logic              ovf_raw;
    logic              less;
    logic              op_legal;

    assign alu_less = 1'b0;
    assign op_legal = (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
                      (op == OP_SUB) || (op == OP_SLT);
    assign sub_q    = (op_q == OP_SUB) || (op_q == OP_SLT);
    assign arith_q  = sub_q || (op_q == OP_ADD);
    assign last     = (idx == IW'(NIBBLES - 1));
    assign nidx     = idx + IW'(1);

    // SLT is decided from the top-nibble sum MSB, corrected by signed overflow of a-b
    assign ovf_raw = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q)) && (alu_set != a_q[WIDTH-1]);
    assign less    = alu_set ^ ovf_raw;

    always_comb begin
        acc_next = acc;
        acc_next[4*idx +: 4] = alu_result;
        fin_result = '0;
        if (legal_q) begin
            if (op_q == OP_SLT) fin_result = {{(WIDTH-1){1'b0}}, less};
            else                fin_result = acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            legal_q  <= 1'b0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_cin  <= 1'b0;
            alu_op   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RUN;
                        idx     <= '0;
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        legal_q <= op_legal;
                        busy    <= 1'b1;
                        if (op_legal) begin
                            alu_a   <= a[3:0];
                            alu_b   <= b[3:0];
                            alu_op  <= (op == OP_SLT) ? OP_SUB : op;
                            alu_cin <= (op == OP_SUB) || (op == OP_SLT);
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_next;
                    if (last) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        result   <= fin_result;
                        zero     <= (fin_result == '0);
                        cout     <= legal_q && arith_q && alu_cout;
                        overflow <= legal_q && arith_q && (op_q != OP_SLT) && ovf_raw;
                        illegal  <= !legal_q;
                        alu_a    <= '0;
                        alu_b    <= '0;
                        alu_cin  <= 1'b0;
                        alu_op   <= '0;
                    end else begin
                        idx <= nidx;
                        if (legal_q) begin
                            alu_a   <= a_q[4*nidx +: 4];
                            alu_b   <= b_q[4*nidx +: 4];
                            alu_cin <= arith_q && alu_cout;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb/tb_alu_nibble_sequencer.sv - self-checking bench for alu_nibble_sequencer
// Word-level reference model plus a per-cycle compare process; slice modelled behaviourally.
module tb_alu_nibble_sequencer;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, zero, cout, overflow, illegal;
    logic [W-1:0] result;
    logic [3:0]   alu_a, alu_b, alu_result;
    logic         alu_cin, alu_less, alu_cout, alu_set;
    logic [2:0]   alu_op;

    int checks = 0;
    int errors = 0;

    alu_nibble_sequencer #(.NIBBLES(N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero), .cout(cout),
        .overflow(overflow), .illegal(illegal), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cin(alu_cin), .alu_less(alu_less), .alu_op(alu_op),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_set(alu_set)
    );

    always #5 clk = ~clk;

    // Behavioural 4-bit slice
    always_comb begin
        logic [4:0] s;
        logic [3:0] bb;
        bb = alu_op[2] ? ~alu_b : alu_b;
        s  = {1'b0, alu_a} + {1'b0, bb} + {4'b0, alu_cin};
        alu_cout = s[4];
        alu_set  = s[3];
        case (alu_op)
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            default: alu_result = s[3:0];
        endcase
    end

    typedef struct packed {
        logic [W-1:0] r;
        logic z, c, v, i;
    } res_t;

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o);
        res_t m;
        logic [W:0] s;
        m = '0;
        s = '0;
        case (o)
            3'b000: m.r = x & y;
            3'b001: m.r = x | y;
            3'b010: begin
                s = {1'b0, x} + {1'b0, y};
                m.r = s[W-1:0];
                m.c = s[W];
                m.v = (x[W-1] == y[W-1]) && (m.r[W-1] != x[W-1]);
            end
            3'b110: begin
                s = {1'b0, x} + {1'b0, ~y} + 1;
                m.r = s[W-1:0];
                m.c = s[W];
                m.v = (x[W-1] != y[W-1]) && (m.r[W-1] != x[W-1]);
            end
            3'b111: begin
                s = {1'b0, x} + {1'b0, ~y} + 1;
                m.c = s[W];
                m.r = ($signed(x) < $signed(y)) ? 1 : 0;
            end
            default: m.i = 1'b1;
        endcase
        m.z = (m.r == '0);
        return m;
    endfunction

    function automatic logic is_legal(input logic [2:0] o);
        return o == 3'b000 || o == 3'b001 || o == 3'b010 || o == 3'b110 || o == 3'b111;
    endfunction

    // Carry into nibble k = carry out of the low 4k bits of the word-level sum
    function automatic logic exp_cin(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o, input int k);
        logic [32:0] mask, sum, bb;
        logic c0;
        if (!(o == 3'b010 || o == 3'b110 || o == 3'b111)) return 1'b0;
        c0 = (o != 3'b010);
        if (k == 0) return c0;
        bb   = {17'b0, (c0 ? ~y : y)};
        mask = (33'd1 << (4 * k)) - 1;
        sum  = ({17'b0, x} & mask) + (bb & mask) + {32'b0, c0};
        return sum[4 * k];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol model: cnt=-1 idle, 0..N-1 nibble being driven, N done cycle
    int           cnt = -1;
    bit           armed = 0;
    logic [W-1:0] ma, mb;
    logic [2:0]   mop;
    res_t         held = '0;

    always @(posedge clk) begin
        if (reset) begin
            cnt = -1;
            held = '0;
            armed = 1;
        end else if (cnt < 0) begin
            if (start) begin
                cnt = 0;
                ma = a;
                mb = b;
                mop = op;
            end
        end else if (cnt == N) begin
            cnt = -1;
        end else begin
            cnt++;
            if (cnt == N) held = model(ma, mb, mop);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("alu_less", {31'b0, alu_less}, 0);
            if (cnt >= 0 && cnt < N) begin
                chk("run_busy", {31'b0, busy}, 1);
                chk("run_done", {31'b0, done}, 0);
                if (is_legal(mop)) begin
                    chk("alu_a", {28'b0, alu_a}, {28'b0, ma[4*cnt +: 4]});
                    chk("alu_b", {28'b0, alu_b}, {28'b0, mb[4*cnt +: 4]});
                    chk("alu_op", {29'b0, alu_op}, {29'b0, (mop == 3'b111) ? 3'b110 : mop});
                    chk("alu_cin", {31'b0, alu_cin}, {31'b0, exp_cin(ma, mb, mop, cnt)});
                end else begin
                    chk("ill_alu", {20'b0, alu_a, alu_b, alu_op, alu_cin}, 0);
                end
            end else begin
                chk(cnt == N ? "done_pulse" : "idle_done", {31'b0, done}, (cnt == N) ? 1 : 0);
                chk(cnt == N ? "done_busy" : "idle_busy", {31'b0, busy}, (cnt == N) ? 1 : 0);
                chk("result", {16'b0, result}, {16'b0, held.r});
                chk("flags", {28'b0, zero, cout, overflow, illegal}, {28'b0, held.z, held.c, held.v, held.i});
                chk("alu_quiet", {20'b0, alu_a, alu_b, alu_op, alu_cin}, 0);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o, input bit hold);
        int i;
        @(negedge clk);
        a = x;
        b = y;
        op = o;
        start = 1'b1;
        for (i = 0; i < 20 && !busy; i++) @(negedge clk);
        start = hold;
        for (i = 0; i < 20 && !done; i++) @(negedge clk);
        if (!done) chk("done_timeout", {31'b0, done}, 1);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 3'($urandom);
    endtask

    res_t p;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_result", {16'b0, result}, 0);
        reset = 1'b0;

        // Pin the reference model with hand-computed values
        p = model(16'h0FFF, 16'h0001, 3'b010);
        chk("pin_add", {12'b0, p.r, p.z, p.c, p.v, p.i}, {12'b0, 16'h1000, 4'b0000});
        p = model(16'h1234, 16'h1234, 3'b110);
        chk("pin_sub", {12'b0, p.r, p.z, p.c, p.v, p.i}, {12'b0, 16'h0000, 4'b1100});
        p = model(16'h8000, 16'h0001, 3'b111);
        chk("pin_slt1", {16'b0, p.r}, 32'h0001);
        p = model(16'h7FFF, 16'h8000, 3'b111);
        chk("pin_slt2", {16'b0, p.r}, 32'h0000);
        p = model(16'h7FFF, 16'h0001, 3'b010);
        chk("pin_ovf", {12'b0, p.r, p.z, p.c, p.v, p.i}, {12'b0, 16'h8000, 4'b0010});
        p = model(16'hF0F0, 16'h0FF0, 3'b000);
        chk("pin_and", {12'b0, p.r, p.z, p.c, p.v, p.i}, {12'b0, 16'h00F0, 4'b0000});
        p = model(16'h1234, 16'h5678, 3'b011);
        chk("pin_ill", {12'b0, p.r, p.z, p.c, p.v, p.i}, {12'b0, 16'h0000, 4'b1001});

        run_op(16'h0FFF, 16'h0001, 3'b010, 0);
        chk("lit_add", {16'b0, result}, 32'h1000);
        run_op(16'h1234, 16'h1234, 3'b110, 1);
        chk("lit_sub_zero", {31'b0, zero}, 1);
        run_op(16'h8000, 16'h0001, 3'b111, 0);
        chk("lit_slt1", {16'b0, result}, 32'h0001);
        run_op(16'h7FFF, 16'h8000, 3'b111, 0);
        chk("lit_slt2", {16'b0, result}, 32'h0000);
        run_op(16'h7FFF, 16'h0001, 3'b010, 0);
        chk("lit_ovf", {31'b0, overflow}, 1);
        run_op(16'hF0F0, 16'h0FF0, 3'b000, 1);
        chk("lit_and", {16'b0, result}, 32'h00F0);
        run_op(16'h1234, 16'h5678, 3'b011, 1);
        chk("lit_illegal", {31'b0, illegal}, 1);

        // Reset in the middle of a run, then a clean op
        @(negedge clk);
        a = 16'hABCD;
        b = 16'h1111;
        op = 3'b010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 0);
        run_op(16'h4321, 16'h1234, 3'b110, 0);

        for (int n = 0; n < 60; n++) begin
            run_op(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
